// File: rtl/arc4_sched.sv
// Sequencer for one ARC4 decryption pass: runs init, ksa and prga in turn
// and hands the single S-memory write port to whichever engine is active.
module arc4_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [1:0]  phase,
   output logic        init_en,
   output logic        ksa_en,
   output logic        prga_en,
   input  logic        init_rdy,
   input  logic        ksa_rdy,
   input  logic        prga_rdy,
   output logic [23:0] ksa_key,
   output logic [23:0] prga_key,
   input  logic [7:0]  init_addr,
   input  logic [7:0]  ksa_addr,
   input  logic [7:0]  prga_addr,
   input  logic [7:0]  init_wrdata,
   input  logic [7:0]  ksa_wrdata,
   input  logic [7:0]  prga_wrdata,
   input  logic        init_wren,
   input  logic        ksa_wren,
   input  logic        prga_wren,
   output logic [7:0]  s_addr,
   output logic [7:0]  s_wrdata,
   output logic        s_wren
);

   typedef enum logic [2:0] {
      IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] key_q, key_d;
   logic        seen_busy_q, seen_busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         key_q       <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         seen_busy_q <= seen_busy_d;
      end
   end

   // An engine counts as finished only after it has been seen busy since its
   // start pulse, so a ready flag left high from before the pulse is ignored.
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      seen_busy_d = seen_busy_q;
      rdy         = 1'b0;
      phase       = 2'd3;
      init_en     = 1'b0;
      ksa_en      = 1'b0;
      prga_en     = 1'b0;
      case (state_q)
         IDLE: begin
            rdy = 1'b1;
            if (en) begin
               key_d   = key;
               state_d = INIT_GO;
            end
         end
         INIT_GO: begin
            phase   = 2'd0;
            init_en = init_rdy;
            if (init_rdy) begin
               seen_busy_d = 1'b0;
               state_d     = INIT_RUN;
            end
         end
         INIT_RUN: begin
            phase = 2'd0;
            if (!init_rdy) seen_busy_d = 1'b1;
            else if (seen_busy_q) state_d = KSA_GO;
         end
         KSA_GO: begin
            phase  = 2'd1;
            ksa_en = ksa_rdy;
            if (ksa_rdy) begin
               seen_busy_d = 1'b0;
               state_d     = KSA_RUN;
            end
         end
         KSA_RUN: begin
            phase = 2'd1;
            if (!ksa_rdy) seen_busy_d = 1'b1;
            else if (seen_busy_q) state_d = PRGA_GO;
         end
         PRGA_GO: begin
            phase   = 2'd2;
            prga_en = prga_rdy;
            if (prga_rdy) begin
               seen_busy_d = 1'b0;
               state_d     = PRGA_RUN;
            end
         end
         PRGA_RUN: begin
            phase = 2'd2;
            if (!prga_rdy) seen_busy_d = 1'b1;
            else if (seen_busy_q) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_addr   = 8'd0;
      s_wrdata = 8'd0;
      s_wren   = 1'b0;
      case (phase)
         2'd0: begin
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
         end
         2'd1: begin
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
         end
         2'd2: begin
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
         end
         default: begin
            s_addr   = 8'd0;
            s_wrdata = 8'd0;
            s_wren   = 1'b0;
         end
      endcase
   end

   assign ksa_key  = key_q;
   assign prga_key = key_q;

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: stub engines with scripted busy/stale/pre-wait timing
// and a cycle-index model of when each phase, pulse and rdy must occur.
module tb_arc4_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [23:0] key = '0;
   logic        rdy;
   logic [1:0]  phase;
   logic        init_en, ksa_en, prga_en;
   logic [2:0]  st_rdy = 3'b111;
   logic [2:0]  st_wr = 3'b000;
   logic [7:0]  st_addr [3];
   logic [7:0]  st_dat [3];
   logic [23:0] ksa_key, prga_key;
   logic [7:0]  s_addr, s_wrdata;
   logic        s_wren;

   arc4_sched dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .phase(phase),
      .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
      .init_rdy(st_rdy[0]), .ksa_rdy(st_rdy[1]), .prga_rdy(st_rdy[2]),
      .ksa_key(ksa_key), .prga_key(prga_key),
      .init_addr(st_addr[0]), .ksa_addr(st_addr[1]), .prga_addr(st_addr[2]),
      .init_wrdata(st_dat[0]), .ksa_wrdata(st_dat[1]), .prga_wrdata(st_dat[2]),
      .init_wren(st_wr[0]), .ksa_wren(st_wr[1]), .prga_wren(st_wr[2]),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
   );

   always #5 clk = ~clk;

   // Model: per engine, w = cycles not ready on entering its phase,
   // s = cycles still ready after its pulse, b = cycles busy afterwards.
   // Cycle n = 1 is the first cycle after the accepting edge.
   int          w [3], s [3], b [3], g [3];
   int          d = 0;
   int          n = 0;
   bit          run_active = 1'b0, pending = 1'b0, chk_on = 1'b0, fixed_mux = 1'b0;
   logic [23:0] key_m = '0, key_nx = '0;
   logic [2:0]  en_seen = 3'b000;
   bit          act [3];
   int          k [3];
   int          p_n [3];
   int          busy_n = 0;
   int          checks = 0, errors = 0;
   int          cyc = 0;

   logic        e_rdy, e_w;
   logic [1:0]  e_ph;
   logic [2:0]  e_en;
   logic [7:0]  e_a, e_d;

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s n=%0d: got %0h expected %0h", nm, n, act_v, exp_v);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle budget exceeded");
         $fatal(1, "cycle budget exceeded");
      end
   end

   always @(negedge clk) begin
      en_seen = {prga_en, ksa_en, init_en};
      if (chk_on) begin
         if (run_active) begin
            e_rdy = 1'b0;
            if (n < g[1])      e_ph = 2'd0;
            else if (n < g[2]) e_ph = 2'd1;
            else if (n < d)    e_ph = 2'd2;
            else               e_ph = 2'd3;
            for (int x = 0; x < 3; x++) e_en[x] = (n == g[x] + w[x]);
         end else begin
            e_rdy = 1'b1;
            e_ph  = 2'd3;
            e_en  = 3'b000;
         end
         if (e_ph == 2'd3) begin
            e_a = 8'd0; e_d = 8'd0; e_w = 1'b0;
         end else begin
            e_a = st_addr[e_ph]; e_d = st_dat[e_ph]; e_w = st_wr[e_ph];
         end
         chk("rdy", 32'(rdy), 32'(e_rdy));
         chk("phase", 32'(phase), 32'(e_ph));
         chk("init_en", 32'(init_en), 32'(e_en[0]));
         chk("ksa_en", 32'(ksa_en), 32'(e_en[1]));
         chk("prga_en", 32'(prga_en), 32'(e_en[2]));
         chk("ksa_key", 32'(ksa_key), 32'(key_m));
         chk("prga_key", 32'(prga_key), 32'(key_m));
         chk("s_addr", 32'(s_addr), 32'(e_a));
         chk("s_wrdata", 32'(s_wrdata), 32'(e_d));
         chk("s_wren", 32'(s_wren), 32'(e_w));
         if (run_active) begin
            if (!rdy) busy_n++;
            for (int x = 0; x < 3; x++) if (en_seen[x]) p_n[x] = n;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (pending) begin
         pending    = 1'b0;
         run_active = 1'b1;
         n          = 1;
         key_m      = key_nx;
         busy_n     = 0;
         for (int x = 0; x < 3; x++) p_n[x] = -1;
      end else if (run_active) begin
         n++;
         if (n > d) run_active = 1'b0;
      end
      for (int x = 0; x < 3; x++) begin
         if (en_seen[x]) begin
            act[x] = 1'b1;
            k[x]   = 1;
         end else if (act[x]) begin
            k[x]++;
            if (k[x] > s[x] + b[x]) act[x] = 1'b0;
         end
         st_rdy[x] = !(act[x] && k[x] > s[x] && k[x] <= s[x] + b[x]) &&
                     !(run_active && n >= g[x] && n < g[x] + w[x]);
         if (fixed_mux) begin
            st_addr[x] = 8'(16 * (x + 1));
            st_dat[x]  = 8'(16 * (x + 1));
            st_wr[x]   = 1'b1;
         end else begin
            st_addr[x] = 8'($urandom);
            st_dat[x]  = 8'($urandom);
            st_wr[x]   = 1'($urandom_range(0, 1));
         end
      end
      en  = run_active ? 1'($urandom_range(0, 1)) : 1'b0;
      key = 24'($urandom);
   endtask

   task automatic start_run(input int w0, input int w1, input int w2,
                            input int s0, input int s1, input int s2,
                            input int b0, input int b1, input int b2,
                            input logic [23:0] kk);
      w[0] = w0; w[1] = w1; w[2] = w2;
      s[0] = s0; s[1] = s1; s[2] = s2;
      b[0] = b0; b[1] = b1; b[2] = b2;
      g[0] = 1;
      g[1] = g[0] + w[0] + s[0] + b[0] + 2;
      g[2] = g[1] + w[1] + s[1] + b[1] + 2;
      d    = g[2] + w[2] + s[2] + b[2] + 2;
      key_nx  = kk;
      key     = kk;
      en      = 1'b1;
      pending = 1'b1;
   endtask

   task automatic run_to_idle();
      int guard = 0;
      do begin
         tick();
         guard++;
      end while ((run_active || pending) && guard < 20000);
   endtask

   initial begin
      for (int x = 0; x < 3; x++) begin
         st_addr[x] = 8'hA5; st_dat[x] = 8'h5A; act[x] = 1'b0; k[x] = 0; p_n[x] = -1;
         w[x] = 0; s[x] = 0; b[x] = 1; g[x] = 0;
      end
      st_wr = 3'b111;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_rdy", 32'(rdy), 32'd1);
      chk("rst_phase", 32'(phase), 32'd3);
      chk("rst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
      chk("rst_s_wren", 32'(s_wren), 32'd0);
      chk("rst_s_addr", 32'(s_addr), 32'd0);
      chk("rst_s_wrdata", 32'(s_wrdata), 32'd0);
      chk("rst_key", 32'(ksa_key), 32'd0);
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_rdy", 32'(rdy), 32'd1);
      chk("rst_hold_phase", 32'(phase), 32'd3);
      en     = 1'b0;
      rst_n  = 1'b1;
      chk_on = 1'b1;
      repeat (10) tick();

      // Full pass with the reference stub timings.
      fixed_mux = 1'b1;
      start_run(0, 0, 0, 0, 0, 0, 256, 768, 5, 24'h000018);
      run_to_idle();
      fixed_mux = 1'b0;
      chk("pass1_init_pulse", 32'(p_n[0]), 32'd1);
      chk("pass1_ksa_pulse", 32'(p_n[1]), 32'd259);
      chk("pass1_prga_pulse", 32'(p_n[2]), 32'd1029);
      chk("pass1_latency", 32'(busy_n), 32'd1036);
      chk("pass1_ksa_key", 32'(ksa_key), 32'h000018);
      chk("pass1_prga_key", 32'(prga_key), 32'h000018);

      // Stale ksa ready (high 3 after pulse, low 4) and prga busy at its GO.
      start_run(0, 0, 3, 0, 3, 0, 2, 4, 2, 24'($urandom));
      run_to_idle();
      chk("pass2_ksa_pulse", 32'(p_n[1]), 32'd5);
      chk("pass2_prga_pulse", 32'(p_n[2]), 32'd17);
      chk("pass2_latency", 32'(busy_n), 32'd21);

      // Asynchronous reset in the middle of the ksa phase, then a restart.
      tick();
      start_run(1, 0, 1, 1, 1, 1, 3, 6, 3, 24'($urandom));
      begin
         int guard = 0;
         while (!(run_active && n == g[1] + 1) && guard < 2000) begin
            tick();
            guard++;
         end
      end
      chk("midrst_phase_before", 32'(phase), 32'd1);
      chk_on = 1'b0;
      st_wr  = 3'b111;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rdy", 32'(rdy), 32'd1);
      chk("midrst_phase", 32'(phase), 32'd3);
      chk("midrst_s_wren", 32'(s_wren), 32'd0);
      chk("midrst_s_addr", 32'(s_addr), 32'd0);
      chk("midrst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
      chk("midrst_key", 32'(ksa_key), 32'd0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      run_active = 1'b0;
      pending    = 1'b0;
      en         = 1'b0;
      key_m      = '0;
      for (int x = 0; x < 3; x++) act[x] = 1'b0;
      st_rdy = 3'b111;
      chk_on = 1'b1;
      repeat (2) tick();
      start_run(0, 1, 0, 2, 0, 1, 4, 3, 2, 24'($urandom));
      run_to_idle();
      chk("restart_init_pulse", 32'(p_n[0]), 32'd1);

      // Randomized passes, some back-to-back in the first idle cycle.
      for (int r = 0; r < 30; r++) begin
         repeat ($urandom_range(0, 3)) tick();
         start_run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                   24'($urandom));
         run_to_idle();
      end
      repeat (3) tick();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
